// File: rtl/sd_data_ctrl.sv
// Control FSM of the SD host data block: sequences single/multi-block transfers and
// supervises the timeout. Define SD_DATA_BLKCNT_EN to expose the Blocks_done count.
module sd_data_ctrl #(
    parameter int unsigned BLK_W = 8,
    parameter int unsigned TO_W  = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             WriteRead,
    input  logic [BLK_W-1:0] Blocks,
    input  logic             MultipleData,
    input  logic             Timeout_enable,
    input  logic [TO_W-1:0]  Timeout_reg,
    input  logic             NewData,
    input  logic             FIFO_ok,
    input  logic             Complete,
    output logic             Send,
    output logic             Idle,
    output logic             Data_transfer_complete,
    output logic             Timeout,
    output logic             Dir
`ifdef SD_DATA_BLKCNT_EN
    ,
    output logic [BLK_W-1:0] Blocks_done
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StCheck,
        StSend,
        StWaitDone,
        StDone,
        StError
    } state_e;

    localparam logic [BLK_W-1:0] BlkOne = BLK_W'(1);
    localparam logic [TO_W-1:0]  ToOne  = TO_W'(1);

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic [BLK_W-1:0] target_q, target_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             send_q, send_d;
    logic             idle_q, idle_d;
    logic             done_q, done_d;
    logic             tout_q, tout_d;
    logic             to_hit;
    logic [BLK_W-1:0] blk_inc;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        target_d  = target_q;
        blk_cnt_d = blk_cnt_q;
        to_cnt_d  = to_cnt_q;
        blk_inc   = blk_cnt_q + BlkOne;
        // Expires on the cycle the counter reaches Timeout_reg-1, i.e. after Timeout_reg cycles
        to_hit    = Timeout_enable && (Timeout_reg != '0) && (to_cnt_q == Timeout_reg - ToOne);

        unique case (state_q)
            StIdle: begin
                if (NewData) begin
                    state_d  = StSetup;
                    dir_d    = WriteRead;
                    target_d = (MultipleData && (Blocks != '0)) ? Blocks : BlkOne;
                end
            end
            StSetup: begin
                state_d   = StCheck;
                blk_cnt_d = '0;
            end
            StCheck: begin
                if (FIFO_ok) begin
                    state_d = StSend;
                end else if (to_hit) begin
                    state_d = StError;
                end
            end
            StSend: state_d = StWaitDone;
            StWaitDone: begin
                // A completion in the expiry cycle still counts; the event beats the timeout
                if (Complete) begin
                    blk_cnt_d = blk_inc;
                    state_d   = (blk_inc == target_q) ? StDone : StCheck;
                end else if (to_hit) begin
                    state_d = StError;
                end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            to_cnt_d = '0;
        end else if (((state_q == StCheck) || (state_q == StWaitDone)) && (to_cnt_q != '1)) begin
            to_cnt_d = to_cnt_q + ToOne;
        end

        send_d = (state_d == StSend);
        idle_d = (state_d == StIdle) || (state_d == StError);
        done_d = (state_d == StDone);
        tout_d = (state_d == StError);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= StIdle;
            dir_q     <= 1'b0;
            target_q  <= '0;
            blk_cnt_q <= '0;
            to_cnt_q  <= '0;
            send_q    <= 1'b0;
            idle_q    <= 1'b1;
            done_q    <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            target_q  <= target_d;
            blk_cnt_q <= blk_cnt_d;
            to_cnt_q  <= to_cnt_d;
            send_q    <= send_d;
            idle_q    <= idle_d;
            done_q    <= done_d;
            tout_q    <= tout_d;
        end
    end

    assign Send                   = send_q;
    assign Idle                   = idle_q;
    assign Data_transfer_complete = done_q;
    assign Timeout                = tout_q;
    assign Dir                    = dir_q;

`ifdef SD_DATA_BLKCNT_EN
    assign Blocks_done = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sd_data_ctrl.sv
// Directed bench for sd_data_ctrl: per-cycle vector table plus hand-written sequences
// for multi-block, FIFO timeout and mid-operation reset.
module tb_sd_data_ctrl;

    logic        clk = 1'b0;
    logic        rst, wr, blocks_mult, te, nd, fifo, comp;
    logic [7:0]  blocks;
    logic [15:0] treg;
    logic        send, idle, dtc, tout, dir;
`ifdef SD_DATA_BLKCNT_EN
    logic [7:0]  blocks_done;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sd_data_ctrl dut (
        .Clock                  (clk),
        .Reset                  (rst),
        .WriteRead              (wr),
        .Blocks                 (blocks),
        .MultipleData           (blocks_mult),
        .Timeout_enable         (te),
        .Timeout_reg            (treg),
        .NewData                (nd),
        .FIFO_ok                (fifo),
        .Complete               (comp),
        .Send                   (send),
        .Idle                   (idle),
        .Data_transfer_complete (dtc),
        .Timeout                (tout),
        .Dir                    (dir)
`ifdef SD_DATA_BLKCNT_EN
        ,
        .Blocks_done            (blocks_done)
`endif
    );

    typedef struct {
        logic        rst, nd, wr, mult;
        logic [7:0]  blocks;
        logic        fifo, comp, te;
        logic [15:0] treg;
        logic [4:0]  exp;   // {Send, Idle, Data_transfer_complete, Timeout, Dir}
    } vec_t;

    vec_t vecs[34];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts one operation and answers every Send with Complete two cycles later
    task automatic run_op(output int sends, output int dones);
        int cd;
        sends = 0;
        dones = 0;
        cd = -1;
        nd = 1'b1;
        tick();
        nd = 1'b0;
        for (int c = 0; c < 300 && dones == 0; c++) begin
            comp = (cd == 0);
            if (cd >= 0) cd--;
            tick();
            if (send) begin
                sends++;
                cd = 2;
            end
            if (dtc) dones++;
        end
        comp = 1'b0;
    endtask

    initial begin
        int sends, dones, n, cd;
        logic saw_send;

        rst = 1'b1; nd = 1'b0; wr = 1'b0; blocks_mult = 1'b0; blocks = '0;
        fifo = 1'b1; comp = 1'b0; te = 1'b0; treg = '0;

        // single write, Blocks ignored when MultipleData=0
        vecs[0]  = '{1, 0, 0, 0, 8'd0, 1, 0, 0, 16'd0, 5'b01000};
        vecs[1]  = '{0, 1, 1, 0, 8'd5, 1, 0, 0, 16'd0, 5'b00001};
        vecs[2]  = '{0, 0, 1, 0, 8'd5, 1, 0, 0, 16'd0, 5'b00001};
        vecs[3]  = '{0, 0, 1, 0, 8'd5, 1, 0, 0, 16'd0, 5'b10001};
        vecs[4]  = '{0, 0, 1, 0, 8'd5, 1, 0, 0, 16'd0, 5'b00001};
        vecs[5]  = '{0, 0, 1, 0, 8'd5, 1, 0, 0, 16'd0, 5'b00001};
        vecs[6]  = '{0, 0, 1, 0, 8'd5, 1, 0, 0, 16'd0, 5'b00001};
        vecs[7]  = '{0, 0, 1, 0, 8'd5, 1, 1, 0, 16'd0, 5'b00101};
        vecs[8]  = '{0, 0, 1, 0, 8'd5, 1, 0, 0, 16'd0, 5'b01001};
        vecs[9]  = '{0, 0, 1, 0, 8'd5, 1, 0, 0, 16'd0, 5'b01001};
        // Blocks=0 with MultipleData=1 is one block; NewData in SEND/WAIT ignored
        vecs[10] = '{0, 1, 0, 1, 8'd0, 1, 0, 0, 16'd0, 5'b00000};
        vecs[11] = '{0, 0, 0, 1, 8'd0, 1, 0, 0, 16'd0, 5'b00000};
        vecs[12] = '{0, 0, 0, 1, 8'd0, 1, 0, 0, 16'd0, 5'b10000};
        vecs[13] = '{0, 1, 0, 1, 8'd0, 1, 0, 0, 16'd0, 5'b00000};
        vecs[14] = '{0, 1, 0, 1, 8'd0, 1, 1, 0, 16'd0, 5'b00100};
        vecs[15] = '{0, 0, 0, 1, 8'd0, 1, 0, 0, 16'd0, 5'b01000};
        // Complete on the expiry cycle (Timeout_reg=4): block counted, no Timeout
        vecs[16] = '{0, 1, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b00001};
        vecs[17] = '{0, 0, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b00001};
        vecs[18] = '{0, 0, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b10001};
        vecs[19] = '{0, 0, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b00001};
        vecs[20] = '{0, 0, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b00001};
        vecs[21] = '{0, 0, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b00001};
        vecs[22] = '{0, 0, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b00001};
        vecs[23] = '{0, 0, 1, 0, 8'd1, 1, 1, 1, 16'd4, 5'b00101};
        vecs[24] = '{0, 0, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b01001};
        // same, Complete withheld: timeout after 4 cycles in WAIT_DONE
        vecs[25] = '{0, 1, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b00001};
        vecs[26] = '{0, 0, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b00001};
        vecs[27] = '{0, 0, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b10001};
        vecs[28] = '{0, 0, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b00001};
        vecs[29] = '{0, 0, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b00001};
        vecs[30] = '{0, 0, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b00001};
        vecs[31] = '{0, 0, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b00001};
        vecs[32] = '{0, 0, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b01011};
        vecs[33] = '{0, 0, 1, 0, 8'd1, 1, 0, 1, 16'd4, 5'b01001};

        for (int i = 0; i < 34; i++) begin
            rst = vecs[i].rst; nd = vecs[i].nd; wr = vecs[i].wr;
            blocks_mult = vecs[i].mult; blocks = vecs[i].blocks; fifo = vecs[i].fifo;
            comp = vecs[i].comp; te = vecs[i].te; treg = vecs[i].treg;
            tick();
            chk($sformatf("vec%0d {send,idle,dtc,tout,dir}", i),
                int'({send, idle, dtc, tout, dir}), int'(vecs[i].exp));
        end

        // multi-block read of 3
        te = 1'b0; treg = '0; wr = 1'b0; blocks_mult = 1'b1; blocks = 8'd3; fifo = 1'b1;
        run_op(sends, dones);
        chk("multi sends", sends, 3);
        chk("multi dones", dones, 1);
        chk("multi dir", int'(dir), 0);
`ifdef SD_DATA_BLKCNT_EN
        chk("multi blocks_done", int'(blocks_done), 3);
`endif
        tick();
        chk("multi idle after", int'(idle), 1);

        // FIFO timeout of 70 cycles
        te = 1'b1; treg = 16'd70; fifo = 1'b0; wr = 1'b1;
        nd = 1'b1;
        tick();
        nd = 1'b0;
        tick();
        n = 0;
        saw_send = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            n++;
            if (send) saw_send = 1'b1;
            if (tout) break;
        end
        chk("fifo timeout cycles", n, 70);
        chk("fifo timeout idle", int'(idle), 1);
        chk("fifo timeout no send", int'(saw_send), 0);
        tick();
        chk("timeout one pulse", int'(tout), 0);

        // reset in WAIT_DONE of block 2 of 4, then restart from block 0
        te = 1'b0; treg = '0; fifo = 1'b1; wr = 1'b1; blocks_mult = 1'b1; blocks = 8'd4;
        nd = 1'b1;
        tick();
        nd = 1'b0;
        sends = 0;
        cd = -1;
        for (int c = 0; c < 300; c++) begin
            comp = (cd == 0);
            if (cd >= 0) cd--;
            tick();
            if (send) begin
                sends++;
                cd = 2;
                if (sends == 2) break;
            end
        end
        comp = 1'b0;
        tick();
        chk("pre-reset sends", sends, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset {idle,dtc,tout,dir}", int'({idle, dtc, tout, dir}), 8);
`ifdef SD_DATA_BLKCNT_EN
        chk("reset blocks_done", int'(blocks_done), 0);
`endif
        tick();
        chk("post-reset no done", int'({idle, dtc}), 2);
        run_op(sends, dones);
        chk("restart sends", sends, 4);
        chk("restart dones", dones, 1);
`ifdef SD_DATA_BLKCNT_EN
        chk("restart blocks_done", int'(blocks_done), 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
